// File: rtl/alignment_collector.sv
// Reverses traceback pairs through a LIFO, tallies match/mismatch/gap columns and checks the score.
// Latency: first out_valid two cycles after end_c (CHECK, then DRAIN); one pop per cycle after that.
// Backpressure: out_valid/out_a/out_b hold until out_ready; traceback input is never stalled.
module alignment_collector #(
    parameter int N              = 128,
    parameter int BitAddr        = $clog2(N + 1),
    parameter int gap_score      = -2,
    parameter int match_score    = 1,
    parameter int mismatch_score = -1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      tb_valid,
    input  logic [2:0]                datoA,
    input  logic [2:0]                datoB,
    input  logic                      end_c,
    input  logic [BitAddr:0]          final_score,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2:0]                out_a,
    output logic [2:0]                out_b,
    output logic                      out_last,
    output logic [$clog2(2*N+1)-1:0]  match_cnt,
    output logic [$clog2(2*N+1)-1:0]  mismatch_cnt,
    output logic [$clog2(2*N+1)-1:0]  gap_cnt,
    output logic                      score_ok,
    output logic                      overflow,
    output logic                      sym_err,
    output logic                      done
);
    localparam int Depth = 2 * N;
    localparam int CntW  = $clog2(2 * N + 1);
    localparam int AW    = $clog2(2 * N);
    localparam int SW    = BitAddr + 4;

    typedef enum logic [2:0] {IDLE, COLLECT, CHECK, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [CntW-1:0]     sp;
    logic [CntW-1:0]     sp_m1;
    logic [5:0]          stack [Depth];
    logic                full, push_ok, pop, a_gap, b_gap, bad_sym;
    logic signed [SW-1:0] score_c, fs_ext;

    assign sp_m1   = sp - CntW'(1);
    assign full    = (sp == CntW'(Depth));
    assign a_gap   = (datoA == 3'd4);
    assign b_gap   = (datoB == 3'd4);
    assign bad_sym = (datoA > 3'd4) || (datoB > 3'd4) || (a_gap && b_gap);
    assign push_ok = (state == COLLECT) && tb_valid && !full;

    assign out_valid = (state == DRAIN) && (sp != '0);
    assign out_last  = out_valid && (sp == CntW'(1));
    assign pop       = out_valid && out_ready;
    assign {out_a, out_b} = out_valid ? stack[sp_m1[AW-1:0]] : 6'd0;

    assign score_c = SW'(int'(match_cnt) * match_score
                       + int'(mismatch_cnt) * mismatch_score
                       + int'(gap_cnt) * gap_score);
    assign fs_ext  = SW'($signed(final_score));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COLLECT;
            COLLECT: if (end_c) state_nxt = CHECK;
            CHECK:   state_nxt = (sp != '0) ? DRAIN : DONE;
            DRAIN:   if (pop && sp == CntW'(1)) state_nxt = DONE;
            DONE:    if (start) state_nxt = COLLECT;
            default: state_nxt = IDLE;
        endcase
    end

    // Array is data-only; sp alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_ok) stack[sp[AW-1:0]] <= {datoA, datoB};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp           <= '0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            gap_cnt      <= '0;
            score_ok     <= 1'b0;
            overflow     <= 1'b0;
            sym_err      <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= (state_nxt == DONE) && (state != DONE);
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sp           <= '0;
                        match_cnt    <= '0;
                        mismatch_cnt <= '0;
                        gap_cnt      <= '0;
                        score_ok     <= 1'b0;
                        overflow     <= 1'b0;
                        sym_err      <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (tb_valid) begin
                        if (bad_sym) sym_err <= 1'b1;
                        if (full) begin
                            overflow <= 1'b1;
                        end else begin
                            sp <= sp + CntW'(1);
                            // Illegal pairs are kept in the stack but excluded from the tally.
                            if (!bad_sym) begin
                                if (a_gap || b_gap)      gap_cnt      <= gap_cnt + CntW'(1);
                                else if (datoA == datoB) match_cnt    <= match_cnt + CntW'(1);
                                else                     mismatch_cnt <= mismatch_cnt + CntW'(1);
                            end
                        end
                    end
                end
                CHECK:   score_ok <= (score_c == fs_ext);
                DRAIN:   if (pop) sp <= sp_m1;
                default: ;
            endcase
        end
    end
endmodule
